// File: rtl/cc_nestcheck_seq.sv
// Registered nest detector: flags pattern A/B after it persists HOLD cycles,
// with exact/overlap matching, sticky flag, which-pattern code and saturating count.
module cc_nestcheck_seq #(
  parameter int                             NESTCHECK_DATAWIDTH = 8,
  parameter logic [NESTCHECK_DATAWIDTH-1:0] NESTCHECK_PATTERN_A = 8'b00100000,
  parameter logic [NESTCHECK_DATAWIDTH-1:0] NESTCHECK_PATTERN_B = 8'b00000100,
  parameter int                             NESTCHECK_HOLD      = 3,
  parameter int                             NESTCHECK_CNTWIDTH  = 8
) (
  input  logic                           CC_NESTCHECK_CLOCK_50,
  input  logic                           CC_NESTCHECK_RESET_InHigh,
  input  logic                           CC_NESTCHECK_enable_InHigh,
  input  logic                           CC_NESTCHECK_mode_In,
  input  logic                           CC_NESTCHECK_clear_InHigh,
  input  logic [NESTCHECK_DATAWIDTH-1:0] CC_NESTCHECK_data_InBUS,
  output logic                           CC_NESTCHECK_OutLow,
  output logic                           CC_NESTCHECK_sticky_OutHigh,
  output logic [1:0]                     CC_NESTCHECK_which_OutBUS,
  output logic [NESTCHECK_CNTWIDTH-1:0]  CC_NESTCHECK_count_OutBUS
);

  // A hold of zero behaves exactly like a hold of one.
  localparam int HOLD_EFF = (NESTCHECK_HOLD < 1) ? 1 : NESTCHECK_HOLD;
  localparam int RUN_W    = (HOLD_EFF < 2) ? 1 : $clog2(HOLD_EFF + 1);
  localparam logic [RUN_W-1:0] HOLD_R = RUN_W'(HOLD_EFF);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_DET  = 2'd2
  } state_t;

  logic clk;
  logic srst;
  assign clk  = CC_NESTCHECK_CLOCK_50;
  assign srst = CC_NESTCHECK_RESET_InHigh;

  state_t                          state_q, state_d;
  logic [RUN_W-1:0]                run_q, run_d;
  logic                            out_low_q, out_low_d;
  logic                            sticky_q, sticky_d;
  logic [1:0]                      which_q, which_d;
  logic [NESTCHECK_CNTWIDTH-1:0]   count_q, count_d;

  logic hit_a, hit_b, match, det_entry;

  always_comb begin
    if (CC_NESTCHECK_mode_In) begin
      hit_a = |(CC_NESTCHECK_data_InBUS & NESTCHECK_PATTERN_A);
      hit_b = |(CC_NESTCHECK_data_InBUS & NESTCHECK_PATTERN_B);
    end else begin
      hit_a = (CC_NESTCHECK_data_InBUS == NESTCHECK_PATTERN_A);
      hit_b = (CC_NESTCHECK_data_InBUS == NESTCHECK_PATTERN_B);
    end
    match = CC_NESTCHECK_enable_InHigh & (hit_a | hit_b);
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      ST_IDLE: begin
        if (match) begin
          run_d   = RUN_ONE;
          state_d = (HOLD_EFF == 1) ? ST_DET : ST_ARM;
        end else begin
          run_d = '0;
        end
      end
      ST_ARM: begin
        if (!match) begin
          state_d = ST_IDLE;
          run_d   = '0;
        end else if ((run_q + RUN_ONE) == HOLD_R) begin
          state_d = ST_DET;
          run_d   = HOLD_R;
        end else begin
          run_d = run_q + RUN_ONE;
        end
      end
      ST_DET: begin
        // A continuous match stays here; the run is already saturated.
        if (!match) begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_comb begin
    det_entry = (state_d == ST_DET) && (state_q != ST_DET);
    out_low_d = (state_d != ST_DET);
    sticky_d  = sticky_q;
    which_d   = which_q;
    count_d   = count_q;
    // Clear first, so a simultaneous detect entry lands on top of cleared values.
    if (CC_NESTCHECK_clear_InHigh) begin
      sticky_d = 1'b0;
      which_d  = 2'b00;
      count_d  = '0;
    end
    if (det_entry) begin
      sticky_d = 1'b1;
      which_d  = {hit_b, hit_a};
      if (count_d != '1) begin
        count_d = count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      run_q     <= '0;
      out_low_q <= 1'b1;
      sticky_q  <= 1'b0;
      which_q   <= 2'b00;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      out_low_q <= out_low_d;
      sticky_q  <= sticky_d;
      which_q   <= which_d;
      count_q   <= count_d;
    end
  end

  assign CC_NESTCHECK_OutLow         = out_low_q;
  assign CC_NESTCHECK_sticky_OutHigh = sticky_q;
  assign CC_NESTCHECK_which_OutBUS   = which_q;
  assign CC_NESTCHECK_count_OutBUS   = count_q;

endmodule

// File: tb/tb_cc_nestcheck_seq.sv
// Directed bench for cc_nestcheck_seq: default instance plus a 2-bit-counter instance
// sharing the same stimulus.
module tb_cc_nestcheck_seq;

  logic       clk = 1'b0;
  logic       srst;
  logic       en;
  logic       mode;
  logic       clr;
  logic [7:0] data;

  logic       out_low, sticky;
  logic [1:0] which;
  logic [7:0] count;
  logic       out_low_c2, sticky_c2;
  logic [1:0] which_c2;
  logic [1:0] count_c2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cc_nestcheck_seq dut (
    .CC_NESTCHECK_CLOCK_50      (clk),
    .CC_NESTCHECK_RESET_InHigh  (srst),
    .CC_NESTCHECK_enable_InHigh (en),
    .CC_NESTCHECK_mode_In       (mode),
    .CC_NESTCHECK_clear_InHigh  (clr),
    .CC_NESTCHECK_data_InBUS    (data),
    .CC_NESTCHECK_OutLow        (out_low),
    .CC_NESTCHECK_sticky_OutHigh(sticky),
    .CC_NESTCHECK_which_OutBUS  (which),
    .CC_NESTCHECK_count_OutBUS  (count)
  );

  cc_nestcheck_seq #(.NESTCHECK_CNTWIDTH(2)) dut_c2 (
    .CC_NESTCHECK_CLOCK_50      (clk),
    .CC_NESTCHECK_RESET_InHigh  (srst),
    .CC_NESTCHECK_enable_InHigh (en),
    .CC_NESTCHECK_mode_In       (mode),
    .CC_NESTCHECK_clear_InHigh  (clr),
    .CC_NESTCHECK_data_InBUS    (data),
    .CC_NESTCHECK_OutLow        (out_low_c2),
    .CC_NESTCHECK_sticky_OutHigh(sticky_c2),
    .CC_NESTCHECK_which_OutBUS  (which_c2),
    .CC_NESTCHECK_count_OutBUS  (count_c2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic o, input logic s,
                           input logic [1:0] w, input logic [7:0] c);
    check_val({tag, ".out"},    {31'd0, out_low}, {31'd0, o});
    check_val({tag, ".sticky"}, {31'd0, sticky},  {31'd0, s});
    check_val({tag, ".which"},  {30'd0, which},   {30'd0, w});
    check_val({tag, ".count"},  {24'd0, count},   {24'd0, c});
  endtask

  // Three matching samples then one idle sample: one complete nest.
  task automatic one_nest();
    data = 8'h20;
    step(); step(); step();
    data = 8'h00;
    step();
  endtask

  initial begin
    srst = 1'b1; en = 1'b1; mode = 1'b0; clr = 1'b0; data = 8'h20;

    // 1: reset held two cycles with a matching row present
    step(); step();
    check_all("t1_reset", 1'b1, 1'b0, 2'b00, 8'd0);

    // 2: exact pattern A held, detect on third edge
    srst = 1'b0;
    step();
    check_val("t2_edge1.out", {31'd0, out_low}, 32'd1);
    step();
    check_val("t2_edge2.out", {31'd0, out_low}, 32'd1);
    step();
    check_all("t2_edge3", 1'b0, 1'b1, 2'b01, 8'd1);
    step(); step();
    check_all("t2_hold", 1'b0, 1'b1, 2'b01, 8'd1);
    data = 8'h00;
    step();
    check_all("t2_release", 1'b1, 1'b1, 2'b01, 8'd1);

    // 3: clear, then pattern B runs that break before HOLD
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_all("t3_clear", 1'b1, 1'b0, 2'b00, 8'd0);
    begin
      logic [7:0] seq [6];
      seq = '{8'h04, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00};
      for (int i = 0; i < 6; i++) begin
        data = seq[i];
        step();
        check_val($sformatf("t3_broken[%0d].out", i), {31'd0, out_low}, 32'd1);
      end
    end
    check_val("t3_broken.count", {24'd0, count}, 32'd0);

    // 4: 0x24 misses both in exact mode, hits both in overlap mode
    data = 8'h24;
    for (int i = 0; i < 4; i++) step();
    check_all("t4_exact", 1'b1, 1'b0, 2'b00, 8'd0);
    mode = 1'b1;
    step(); step();
    check_val("t4_overlap2.out", {31'd0, out_low}, 32'd1);
    step();
    check_all("t4_overlap3", 1'b0, 1'b1, 2'b11, 8'd1);
    data = 8'h00;
    mode = 1'b0;
    step();
    check_val("t4_release.out", {31'd0, out_low}, 32'd1);

    // 5: four more nests saturate the 2-bit counter, then clear on a detect edge
    for (int i = 0; i < 4; i++) one_nest();
    check_val("t5_sat.count8", {24'd0, count}, 32'd5);
    check_val("t5_sat.count2", {30'd0, count_c2}, 32'd3);
    check_val("t5_sat.which2", {30'd0, which_c2}, 32'd1);
    data = 8'h20;
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_all("t5_clear_det", 1'b0, 1'b1, 2'b01, 8'd1);
    check_val("t5_clear_det.count2", {30'd0, count_c2}, 32'd1);
    check_val("t5_clear_det.sticky2", {31'd0, sticky_c2}, 32'd1);
    check_val("t5_clear_det.out2", {31'd0, out_low_c2}, 32'd0);

    // enable drop while detected: output releases, history retained
    en = 1'b0;
    step();
    check_all("t5_disable", 1'b1, 1'b1, 2'b01, 8'd1);
    en = 1'b1;
    step(); step();
    check_val("t5_reen2.out", {31'd0, out_low}, 32'd1);
    step();
    check_all("t5_reen3", 1'b0, 1'b1, 2'b01, 8'd2);

    // 6: reset while detected, then a fresh run of three is needed
    srst = 1'b1;
    step();
    check_all("t6_reset", 1'b1, 1'b0, 2'b00, 8'd0);
    srst = 1'b0;
    step(); step();
    check_val("t6_rearm2.out", {31'd0, out_low}, 32'd1);
    step();
    check_all("t6_rearm3", 1'b0, 1'b1, 2'b01, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
